traffic_light_monitor: RTL

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

---
 rtl/traffic_light_monitor.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/traffic_light_monitor.sv
// Safety monitor for a four-lane traffic controller: flags illegal light states and latches the first fault.
// Green-phase statistics are built only when MONITOR_STATS_EN is defined.
module traffic_light_monitor #(
  parameter int MIN_YELLOW = 3,
  parameter int MAX_GREEN  = 200,
  parameter int ALLRED_MIN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  NS1_light,
  input  logic [3:0]  NS2_light,
  input  logic [3:0]  EW1_light,
  input  logic [3:0]  EW2_light,
  input  logic        ack_fault,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic [1:0]  fault_lane,
  output logic        force_red,
  output logic [15:0] phase_count
);

  localparam logic [3:0] RED    = 4'b0001;
  localparam logic [3:0] YELLOW = 4'b0010;
  localparam logic [3:0] GREEN  = 4'b0100;
  localparam logic [3:0] ARROW  = 4'b1000;

  localparam logic [7:0] MinYellow = 8'(MIN_YELLOW);
  localparam logic [7:0] MaxGreen  = 8'(MAX_GREEN);
  localparam logic [7:0] AllRedMin = 8'(ALLRED_MIN);

  typedef enum logic [1:0] {
    MONITOR,
    FAULT,
    RECOVER
  } state_t;

  logic [3:0] light_in [4];
  logic [3:0] cur_q    [4];
  logic [3:0] prev_q   [4];
  logic [7:0] cnt_q    [4];
  logic [7:0] cnt_d    [4];

  logic [3:0] invalid;
  logic [3:0] green_to_red;
  logic [3:0] short_yellow;
  logic [3:0] stuck_green;
  logic [3:0] active;
  logic       conflict;
  logic       all_red;

  logic       flag_any;
  logic [2:0] flag_code;
  logic [1:0] flag_lane;

  state_t     state_q;
  logic       fault_q;
  logic [2:0] code_q;
  logic [1:0] lane_q;
  logic       force_q;
  logic [7:0] allred_q;

  assign light_in[0] = NS1_light;
  assign light_in[1] = NS2_light;
  assign light_in[2] = EW1_light;
  assign light_in[3] = EW2_light;

  function automatic logic [1:0] lowLane(input logic [3:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  // Counter tracks the run length of the value now sitting in prev, so on a yellow exit it holds the yellow duration.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      if (cur_q[i] != prev_q[i])
        cnt_d[i] = 8'd1;
      else if (cnt_q[i] != 8'hFF)
        cnt_d[i] = cnt_q[i] + 8'd1;
      else
        cnt_d[i] = cnt_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        cur_q[i]  <= RED;
        prev_q[i] <= RED;
        cnt_q[i]  <= 8'd0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        cur_q[i]  <= light_in[i];
        prev_q[i] <= cur_q[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  always_comb begin
    invalid      = '0;
    green_to_red = '0;
    short_yellow = '0;
    stuck_green  = '0;
    active       = '0;
    for (int i = 0; i < 4; i++) begin
      invalid[i]      = !$onehot(cur_q[i]);
      green_to_red[i] = ((prev_q[i] == GREEN) || (prev_q[i] == ARROW)) && (cur_q[i] == RED);
      short_yellow[i] = (prev_q[i] == YELLOW) && (cur_q[i] != YELLOW) && (cnt_q[i] < MinYellow);
      stuck_green[i]  = (cur_q[i] == GREEN) && (cnt_q[i] == MaxGreen);
      active[i]       = |cur_q[i][3:1];
    end
  end

  assign conflict = (active[0] | active[1]) & (active[2] | active[3]);
  assign all_red  = (cur_q[0] == RED) && (cur_q[1] == RED) && (cur_q[2] == RED) && (cur_q[3] == RED);

  // Lowest code wins, then lowest lane; a conflict reports the lowest NS lane involved.
  always_comb begin
    flag_any  = 1'b1;
    flag_code = 3'd0;
    flag_lane = 2'd0;
    if (|invalid) begin
      flag_code = 3'd1;
      flag_lane = lowLane(invalid);
    end else if (conflict) begin
      flag_code = 3'd2;
      flag_lane = active[0] ? 2'd0 : 2'd1;
    end else if (|green_to_red) begin
      flag_code = 3'd3;
      flag_lane = lowLane(green_to_red);
    end else if (|short_yellow) begin
      flag_code = 3'd4;
      flag_lane = lowLane(short_yellow);
    end else if (|stuck_green) begin
      flag_code = 3'd5;
      flag_lane = lowLane(stuck_green);
    end else begin
      flag_any  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MONITOR;
      fault_q  <= 1'b0;
      code_q   <= 3'd0;
      lane_q   <= 2'd0;
      force_q  <= 1'b0;
      allred_q <= 8'd0;
    end else begin
      case (state_q)
        MONITOR: begin
          if (flag_any) begin
            state_q <= FAULT;
            fault_q <= 1'b1;
            force_q <= 1'b1;
            code_q  <= flag_code;
            lane_q  <= flag_lane;
          end
        end
        FAULT: begin
          if (ack_fault) begin
            state_q  <= RECOVER;
            allred_q <= 8'd0;
          end
        end
        RECOVER: begin
          if (!all_red) begin
            allred_q <= 8'd0;
          end else if (allred_q + 8'd1 >= AllRedMin) begin
            state_q  <= MONITOR;
            fault_q  <= 1'b0;
            force_q  <= 1'b0;
            code_q   <= 3'd0;
            lane_q   <= 2'd0;
            allred_q <= 8'd0;
          end else begin
            allred_q <= allred_q + 8'd1;
          end
        end
        default: state_q <= MONITOR;
      endcase
    end
  end

  assign fault      = fault_q;
  assign fault_code = code_q;
  assign fault_lane = lane_q;
  assign force_red  = force_q;

`ifdef MONITOR_STATS_EN
  logic [15:0] phase_q;
  logic [2:0]  g2y_sum;
  logic [16:0] phase_sum;

  // Several lanes may leave green in the same cycle; each counts as its own phase.
  always_comb begin
    g2y_sum = 3'd0;
    for (int i = 0; i < 4; i++)
      g2y_sum = g2y_sum + {2'b00, ((prev_q[i] == GREEN) && (cur_q[i] == YELLOW))};
    phase_sum = {1'b0, phase_q} + {14'd0, g2y_sum};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      phase_q <= 16'd0;
    else
      phase_q <= phase_sum[16] ? 16'hFFFF : phase_sum[15:0];
  end

  assign phase_count = phase_q;
`else
  assign phase_count = 16'd0;
`endif

endmodule
